// File: rtl/pls_pkg.sv
// Shared encodings for the PLS indication mapper: filter FSM states and
// the PLS primitive level constants.
package pls_pkg;

  typedef enum logic [1:0] {
    FLT_LOW  = 2'b00,
    FLT_RISE = 2'b01,
    FLT_HIGH = 2'b11,
    FLT_FALL = 2'b10
  } flt_state_e;

  localparam logic SIGNAL_ERROR = 1'b1;
  localparam logic CARRIER_ON   = 1'b1;

endpackage

// File: rtl/pls_level_filter.sv
// Glitch filter: the registered output follows din only after FILTER_LEN
// consecutive samples at the new level.
module pls_level_filter
  import pls_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 2
) (
  input  logic clk,
  input  logic reset_L,
  input  logic din,
  output logic dout
);

  localparam logic [3:0] LEN = 4'(FILTER_LEN);

  flt_state_e state_q, state_d;
  logic [3:0] run_q, run_d;
  logic [3:0] run_inc;
  logic       dout_q, dout_d;

  // Next-state, run-length and output decode
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    run_inc = run_q + 4'd1;
    case (state_q)
      FLT_LOW: begin
        if (din) begin
          if (FILTER_LEN == 1) begin
            state_d = FLT_HIGH;
            run_d   = '0;
          end else begin
            state_d = FLT_RISE;
            run_d   = 4'd1;
          end
        end
      end
      FLT_RISE: begin
        if (din) begin
          if (run_inc == LEN) begin
            state_d = FLT_HIGH;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end else begin
          state_d = FLT_LOW;
          run_d   = '0;
        end
      end
      FLT_HIGH: begin
        if (!din) begin
          if (FILTER_LEN == 1) begin
            state_d = FLT_LOW;
            run_d   = '0;
          end else begin
            state_d = FLT_FALL;
            run_d   = 4'd1;
          end
        end
      end
      FLT_FALL: begin
        if (!din) begin
          if (run_inc == LEN) begin
            state_d = FLT_LOW;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end else begin
          state_d = FLT_HIGH;
          run_d   = '0;
        end
      end
      default: begin
        state_d = FLT_LOW;
        run_d   = '0;
      end
    endcase
    // Output is taken from the next state so it changes on the qualifying edge
    dout_d = (state_d == FLT_HIGH) || (state_d == FLT_FALL);
  end

  // State, run counter and output registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= FLT_LOW;
      run_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/pls_indication_mapper.sv
// Multi-channel MII col/crs to PLS_SIGNAL/PLS_CARRIER indication mapper with
// glitch filters, duplex gating, collision event pulses and saturating counters.
module pls_indication_mapper
  import pls_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned FILTER_LEN = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [N_CH-1:0]       col,
  input  logic [N_CH-1:0]       crs,
  input  logic [N_CH-1:0]       duplex_full,
  input  logic [N_CH-1:0]       cnt_clr,
  output logic [N_CH-1:0]       pls_signal_indication,
  output logic [N_CH-1:0]       pls_carrier_indication,
  output logic [N_CH-1:0]       col_event,
  output logic [N_CH*CNT_W-1:0] col_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_CH-1:0]       col_gated;
  logic [N_CH-1:0]       sig_prev_q, sig_prev_d;
  logic [N_CH*CNT_W-1:0] cnt_q, cnt_d;

  // Full-duplex channels never present a collision to the filter
  assign col_gated = col & ~duplex_full;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pls_level_filter #(.FILTER_LEN(FILTER_LEN)) u_col_flt (
      .clk     (clk),
      .reset_L (reset_L),
      .din     (col_gated[i]),
      .dout    (pls_signal_indication[i])
    );
    pls_level_filter #(.FILTER_LEN(FILTER_LEN)) u_crs_flt (
      .clk     (clk),
      .reset_L (reset_L),
      .din     (crs[i]),
      .dout    (pls_carrier_indication[i])
    );
  end

  // Event is the first cycle SIGNAL_ERROR is seen; counters update on it
  always_comb begin
    logic [CNT_W-1:0] cur;
    cur        = '0;
    sig_prev_d = pls_signal_indication;
    col_event  = pls_signal_indication & ~sig_prev_q;
    cnt_d      = cnt_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cur = cnt_q[i*CNT_W +: CNT_W];
      if (col_event[i] && (pls_signal_indication[i] == SIGNAL_ERROR)) begin
        // A clear coinciding with an event restarts the count at one
        if (cnt_clr[i])           cnt_d[i*CNT_W +: CNT_W] = CNT_ONE;
        else if (cur != CNT_MAX)  cnt_d[i*CNT_W +: CNT_W] = cur + CNT_ONE;
      end else if (cnt_clr[i]) begin
        cnt_d[i*CNT_W +: CNT_W] = '0;
      end
    end
  end

  // Previous-indication and counter registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sig_prev_q <= '0;
      cnt_q      <= '0;
    end else begin
      sig_prev_q <= sig_prev_d;
      cnt_q      <= cnt_d;
    end
  end

  assign col_count = cnt_q;

endmodule

// File: tb/tb_pls_indication_mapper.sv
// Directed bench for pls_indication_mapper: a 4-channel FILTER_LEN=2 CNT_W=2
// instance and a 1-channel FILTER_LEN=1 CNT_W=8 instance.
module tb_pls_indication_mapper;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [3:0] col, crs, dup, clr;
  logic [3:0] sig, car, ev;
  logic [7:0] cnt;

  logic       col1, crs1, dup1, clr1;
  logic       sig1, car1, ev1;
  logic [7:0] cnt1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pls_indication_mapper #(.N_CH(4), .FILTER_LEN(2), .CNT_W(2)) dut (
    .clk                    (clk),
    .reset_L                (reset_L),
    .col                    (col),
    .crs                    (crs),
    .duplex_full            (dup),
    .cnt_clr                (clr),
    .pls_signal_indication  (sig),
    .pls_carrier_indication (car),
    .col_event              (ev),
    .col_count              (cnt)
  );

  pls_indication_mapper #(.N_CH(1), .FILTER_LEN(1), .CNT_W(8)) dut1 (
    .clk                    (clk),
    .reset_L                (reset_L),
    .col                    (col1),
    .crs                    (crs1),
    .duplex_full            (dup1),
    .cnt_clr                (clr1),
    .pls_signal_indication  (sig1),
    .pls_carrier_indication (car1),
    .col_event              (ev1),
    .col_count              (cnt1)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_all();
    clr = 4'hF;
    tick();
    clr = 4'h0;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    col = '0; crs = '0; dup = '0; clr = '0;
    col1 = 1'b0; crs1 = 1'b0; dup1 = 1'b0; clr1 = 1'b0;
    tick(); tick();
    total++; if (sig !== 4'h0) $display("FAIL reset_sig got=%h exp=0", sig); else passed++;
    total++; if (car !== 4'h0) $display("FAIL reset_car got=%h exp=0", car); else passed++;
    total++; if (ev !== 4'h0) $display("FAIL reset_ev got=%h exp=0", ev); else passed++;
    total++; if (cnt !== 8'h00) $display("FAIL reset_cnt got=%h exp=0", cnt); else passed++;
    total++; if ({sig1, car1, ev1, cnt1} !== 11'h0) $display("FAIL reset_dut1 got=%h exp=0", {sig1, car1, ev1, cnt1}); else passed++;
    reset_L = 1'b1;
    tick();
  endtask

  task automatic test_fl1();
    col1 = 1'b1;
    tick();
    total++; if (sig1 !== 1'b1) $display("FAIL fl1_rise1 got=%b exp=1", sig1); else passed++;
    total++; if (ev1 !== 1'b1) $display("FAIL fl1_ev1 got=%b exp=1", ev1); else passed++;
    tick();
    total++; if (ev1 !== 1'b0) $display("FAIL fl1_ev1_end got=%b exp=0", ev1); else passed++;
    total++; if (cnt1 !== 8'd1) $display("FAIL fl1_cnt1 got=%0d exp=1", cnt1); else passed++;
    col1 = 1'b0;
    tick();
    total++; if (sig1 !== 1'b0) $display("FAIL fl1_fall got=%b exp=0", sig1); else passed++;
    tick(); tick();
    col1 = 1'b1;
    tick();
    total++; if (ev1 !== 1'b1) $display("FAIL fl1_ev2 got=%b exp=1", ev1); else passed++;
    tick();
    total++; if (cnt1 !== 8'd2) $display("FAIL fl1_cnt2 got=%0d exp=2", cnt1); else passed++;
    col1 = 1'b0;
    tick();
  endtask

  task automatic test_glitch();
    clear_all();
    col = 4'b0001;
    tick();
    col = 4'b0000;
    tick();
    total++; if (sig[0] !== 1'b0) $display("FAIL short_pulse_sig got=%b exp=0", sig[0]); else passed++;
    tick();
    total++; if (ev[0] !== 1'b0 || cnt[1:0] !== 2'd0) $display("FAIL short_pulse_ev got=%b/%0d exp=0/0", ev[0], cnt[1:0]); else passed++;
    col = 4'b0001;
    tick();
    total++; if (sig[0] !== 1'b0) $display("FAIL rise_first got=%b exp=0", sig[0]); else passed++;
    tick();
    total++; if (sig[0] !== 1'b1 || ev[0] !== 1'b1) $display("FAIL rise_second got=%b/%b exp=1/1", sig[0], ev[0]); else passed++;
    col = 4'b0000;
    tick();
    total++; if (sig[0] !== 1'b1) $display("FAIL low_glitch_hold got=%b exp=1", sig[0]); else passed++;
    col = 4'b0001;
    tick();
    total++; if (sig[0] !== 1'b1 || ev[0] !== 1'b0) $display("FAIL low_glitch_recover got=%b/%b exp=1/0", sig[0], ev[0]); else passed++;
    total++; if (cnt[1:0] !== 2'd1) $display("FAIL glitch_cnt got=%0d exp=1", cnt[1:0]); else passed++;
    col = 4'b0000;
    tick();
    total++; if (sig[0] !== 1'b1) $display("FAIL fall_first got=%b exp=1", sig[0]); else passed++;
    tick();
    total++; if (sig[0] !== 1'b0) $display("FAIL fall_second got=%b exp=0", sig[0]); else passed++;
  endtask

  task automatic test_duplex();
    clear_all();
    dup = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      col = 4'b0011;
      tick(); tick();
      total++; if (ev !== 4'b0001 || sig !== 4'b0001) $display("FAIL duplex_ev iter=%0d got=%b/%b exp=0001/0001", k, ev, sig); else passed++;
      col = 4'b0000;
      tick(); tick();
    end
    total++; if (cnt[3:0] !== 4'b0010) $display("FAIL duplex_cnt got=%h exp=2", cnt[3:0]); else passed++;
    // Duplex switched on mid-collision: indication releases with normal latency
    col = 4'b0001;
    tick(); tick();
    dup = 4'b0011;
    tick();
    total++; if (sig[0] !== 1'b1) $display("FAIL duplex_switch_hold got=%b exp=1", sig[0]); else passed++;
    tick();
    total++; if (sig[0] !== 1'b0) $display("FAIL duplex_switch_release got=%b exp=0", sig[0]); else passed++;
    col = 4'b0000; dup = 4'b0000;
    tick();
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clear_all();
    total++; if (cnt !== 8'h00) $display("FAIL clear_all got=%h exp=0", cnt); else passed++;
    for (int k = 0; k < 5; k++) begin
      col = 4'b0100;
      tick(); tick();
      col = 4'b0000;
      tick();
      total++; if (cnt[5:4] !== exp_cnt[k]) $display("FAIL sat_cnt n=%0d got=%0d exp=%0d", k, cnt[5:4], exp_cnt[k]); else passed++;
      tick();
    end
    col = 4'b0100;
    tick(); tick();
    clr = 4'b0100;
    col = 4'b0000;
    tick();
    clr = 4'b0000;
    total++; if (cnt[5:4] !== 2'd1) $display("FAIL clr_with_event got=%0d exp=1", cnt[5:4]); else passed++;
    tick();
    clr = 4'b0100;
    tick();
    clr = 4'b0000;
    total++; if (cnt[5:4] !== 2'd0) $display("FAIL clr_alone got=%0d exp=0", cnt[5:4]); else passed++;
  endtask

  task automatic test_reset_mid();
    clear_all();
    col = 4'b0001;
    tick(); tick(); tick();
    #2 reset_L = 1'b0;
    #1;
    total++; if (sig !== 4'h0 || ev !== 4'h0 || cnt !== 8'h00) $display("FAIL async_reset got=%h/%h/%h exp=0/0/0", sig, ev, cnt); else passed++;
    tick();
    reset_L = 1'b1;
    tick();
    total++; if (sig[0] !== 1'b0) $display("FAIL post_reset_first got=%b exp=0", sig[0]); else passed++;
    tick();
    total++; if (sig[0] !== 1'b1 || ev[0] !== 1'b1) $display("FAIL post_reset_event got=%b/%b exp=1/1", sig[0], ev[0]); else passed++;
    tick();
    total++; if (cnt[1:0] !== 2'd1) $display("FAIL post_reset_cnt got=%0d exp=1", cnt[1:0]); else passed++;
    col = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    clear_all();
    col = 4'hF; crs = 4'hF;
    tick();
    total++; if (car !== 4'h0 || sig !== 4'h0) $display("FAIL simul_first got=%h/%h exp=0/0", car, sig); else passed++;
    tick();
    total++; if (car !== 4'hF) $display("FAIL simul_car got=%h exp=f", car); else passed++;
    total++; if (ev !== 4'hF) $display("FAIL simul_ev got=%h exp=f", ev); else passed++;
    tick();
    total++; if (ev !== 4'h0 || cnt !== 8'h55) $display("FAIL simul_cnt got=%h/%h exp=0/55", ev, cnt); else passed++;
    crs = 4'b1101;
    tick();
    total++; if (car !== 4'hF) $display("FAIL crs_fall_first got=%h exp=f", car); else passed++;
    tick();
    total++; if (car !== 4'b1101) $display("FAIL crs_fall_second got=%h exp=d", car); else passed++;
    col = 4'h0; crs = 4'h0;
    tick(); tick();
    total++; if (sig !== 4'h0 || car !== 4'h0) $display("FAIL all_idle got=%h/%h exp=0/0", sig, car); else passed++;
  endtask

  initial begin
    test_reset();
    test_fl1();
    test_glitch();
    test_duplex();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
